core_l2_request_arbiter: RTL and testbench

Merges the L2 request streams of one core into a single registered request port toward the L2 cache. The sources are the instruction-cache load miss queue, the data-cache load miss queue and the store buffer. It also decodes L2 responses into per-unit `for_me` strobes. It sits directly downstream of each `l2req_packet` producer and upstream of the L2 request interconnect. Each source holds its packet until its `ready` is asserted, so the L2-ready handshake keeps its meaning at the sources.

---
 rtl/core_l2_request_arbiter.sv | 134 +++++++++++++
 tb/tb_core_l2_request_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_l2_request_arbiter.sv
// Per-core L2 request arbiter: round-robin merge of I-cache LMQ, D-cache LMQ and
// store buffer requests into one registered L2 request, plus response decode.
package core_l2_pkg;

    typedef struct packed {
        logic        valid;
        logic [1:0]  core;
        logic [1:0]  unit;
        logic        write;
        logic [39:0] address;
        logic [63:0] data;
    } l2req_packet_t;

    typedef struct packed {
        logic        valid;
        logic [1:0]  core;
        logic [1:0]  unit;
        logic [63:0] data;
    } l2rsp_packet_t;

endpackage

module core_l2_request_arbiter
    import core_l2_pkg::*;
#(
    parameter int unsigned CORE_ID = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  l2req_packet_t icache_req,
    output logic          icache_ready,
    input  l2req_packet_t dcache_req,
    output logic          dcache_ready,
    input  l2req_packet_t stbuf_req,
    output logic          stbuf_ready,
    output l2req_packet_t l2req_packet,
    input  logic          l2req_ready,
    input  l2rsp_packet_t l2rsp_packet,
    output logic          icache_rsp_for_me,
    output logic          dcache_rsp_for_me,
    output logic          stbuf_rsp_for_me
);

    localparam logic [1:0] CORE_ID_L   = CORE_ID[1:0];
    localparam logic [1:0] UNIT_ICACHE = 2'd0;
    localparam logic [1:0] UNIT_DCACHE = 2'd1;
    localparam logic [1:0] UNIT_STBUF  = 2'd2;

    l2req_packet_t out_q;
    logic [1:0]    rr;

    logic          load_en;
    logic [2:0]    req_vec;
    logic          grant_found;
    logic [1:0]    grant_idx;
    logic [1:0]    next_rr;
    logic          capture;
    l2req_packet_t grant_pkt;

    assign load_en = !out_q.valid || l2req_ready;
    assign req_vec = {stbuf_req.valid, dcache_req.valid, icache_req.valid};

    // Round-robin search starting at rr, wrapping 2 -> 0; index 3 is never a candidate.
    always_comb begin
        logic [1:0] cand;
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        cand        = (rr == 2'd3) ? 2'd0 : rr;
        for (int k = 0; k < 3; k++) begin
            if (!grant_found && req_vec[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
        end
    end

    always_comb begin
        grant_pkt = '0;
        case (grant_idx)
            UNIT_ICACHE: grant_pkt = icache_req;
            UNIT_DCACHE: grant_pkt = dcache_req;
            UNIT_STBUF:  grant_pkt = stbuf_req;
            default:     grant_pkt = '0;
        endcase
    end

    assign next_rr = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;

    // Readies are gated by reset so no source sees a capture that the register will drop.
    assign capture      = load_en && grant_found && !reset;
    assign icache_ready = capture && (grant_idx == UNIT_ICACHE);
    assign dcache_ready = capture && (grant_idx == UNIT_DCACHE);
    assign stbuf_ready  = capture && (grant_idx == UNIT_STBUF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
            rr    <= 2'd0;
        end else if (load_en) begin
            if (grant_found) begin
                out_q <= grant_pkt;
                rr    <= next_rr;
            end else begin
                out_q.valid <= 1'b0;
            end
        end
    end

    assign l2req_packet = out_q;

    assign icache_rsp_for_me = l2rsp_packet.valid && (l2rsp_packet.core == CORE_ID_L)
                               && (l2rsp_packet.unit == UNIT_ICACHE);
    assign dcache_rsp_for_me = l2rsp_packet.valid && (l2rsp_packet.core == CORE_ID_L)
                               && (l2rsp_packet.unit == UNIT_DCACHE);
    assign stbuf_rsp_for_me  = l2rsp_packet.valid && (l2rsp_packet.core == CORE_ID_L)
                               && (l2rsp_packet.unit == UNIT_STBUF);

    // Sources must hold a pending packet unchanged until it is readied.
    a_icache_hold: assert property (@(posedge clk) disable iff (reset)
        (icache_req.valid && !icache_ready) |=> (icache_req.valid && $stable(icache_req)));
    a_dcache_hold: assert property (@(posedge clk) disable iff (reset)
        (dcache_req.valid && !dcache_ready) |=> (dcache_req.valid && $stable(dcache_req)));
    a_stbuf_hold: assert property (@(posedge clk) disable iff (reset)
        (stbuf_req.valid && !stbuf_ready) |=> (stbuf_req.valid && $stable(stbuf_req)));

    a_icache_id: assert property (@(posedge clk) disable iff (reset)
        icache_ready |-> (icache_req.core == CORE_ID_L && icache_req.unit == UNIT_ICACHE));
    a_dcache_id: assert property (@(posedge clk) disable iff (reset)
        dcache_ready |-> (dcache_req.core == CORE_ID_L && dcache_req.unit == UNIT_DCACHE));
    a_stbuf_id: assert property (@(posedge clk) disable iff (reset)
        stbuf_ready |-> (stbuf_req.core == CORE_ID_L && stbuf_req.unit == UNIT_STBUF));

endmodule

// File: tb/tb_core_l2_request_arbiter.sv
// Scoreboard bench for core_l2_request_arbiter: directed stimulus pushes expected
// L2 packets, a negedge monitor pops and compares every accepted L2 request.
module tb_core_l2_request_arbiter;
    import core_l2_pkg::*;

    localparam int         CORE_ID = 0;
    localparam logic [1:0] CID     = 2'(CORE_ID);

    logic          clk = 1'b0;
    logic          reset;
    l2req_packet_t icache_req, dcache_req, stbuf_req;
    logic          icache_ready, dcache_ready, stbuf_ready;
    l2req_packet_t l2req_packet;
    logic          l2req_ready;
    l2rsp_packet_t l2rsp_packet;
    logic          icache_rsp_for_me, dcache_rsp_for_me, stbuf_rsp_for_me;

    int errors = 0;
    int checks = 0;
    l2req_packet_t exp_q[$];

    core_l2_request_arbiter #(.CORE_ID(CORE_ID)) dut (
        .clk               (clk),
        .reset             (reset),
        .icache_req        (icache_req),
        .icache_ready      (icache_ready),
        .dcache_req        (dcache_req),
        .dcache_ready      (dcache_ready),
        .stbuf_req         (stbuf_req),
        .stbuf_ready       (stbuf_ready),
        .l2req_packet      (l2req_packet),
        .l2req_ready       (l2req_ready),
        .l2rsp_packet      (l2rsp_packet),
        .icache_rsp_for_me (icache_rsp_for_me),
        .dcache_rsp_for_me (dcache_rsp_for_me),
        .stbuf_rsp_for_me  (stbuf_rsp_for_me)
    );

    always #5 clk = ~clk;

    function automatic l2req_packet_t mk(input logic [1:0] unit, input logic [39:0] addr,
                                         input logic wr, input logic [63:0] data);
        l2req_packet_t p;
        p.valid   = 1'b1;
        p.core    = CID;
        p.unit    = unit;
        p.write   = wr;
        p.address = addr;
        p.data    = data;
        return p;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of source inputs, check the combinational readies, then advance.
    task automatic applyStimulus(input l2req_packet_t i, input l2req_packet_t d,
                                 input l2req_packet_t s, input logic l2rdy,
                                 input logic [2:0] exp_ready, input string name);
        icache_req  = i;
        dcache_req  = d;
        stbuf_req   = s;
        l2req_ready = l2rdy;
        #2;
        checkOutput(name, 128'({stbuf_ready, dcache_ready, icache_ready}), 128'(exp_ready));
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        icache_req  = '0;
        dcache_req  = '0;
        stbuf_req   = '0;
        l2req_ready = 1'b0;
        reset       = 1'b1;
        #2;
        checkOutput("reset packet", 128'(l2req_packet), 128'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic checkRsp(input logic v, input logic [1:0] core, input logic [1:0] unit,
                            input logic [2:0] exp_strobes, input string name);
        l2rsp_packet.valid = v;
        l2rsp_packet.core  = core;
        l2rsp_packet.unit  = unit;
        l2rsp_packet.data  = 64'hFEED;
        #1;
        checkOutput(name, 128'({stbuf_rsp_for_me, dcache_rsp_for_me, icache_rsp_for_me}),
                    128'(exp_strobes));
    endtask

    // Accepted L2 requests are compared in order against the expected queue.
    always @(negedge clk) begin
        if (!reset && l2req_packet.valid && l2req_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard: got unexpected packet %0h expected none",
                         l2req_packet);
            end else begin
                l2req_packet_t e;
                e = exp_q.pop_front();
                checkOutput("scoreboard", 128'(l2req_packet), 128'(e));
            end
        end
    end

    initial begin
        l2req_packet_t idle;
        l2req_packet_t a0, a1, d0, d1, s0, s1, ix, d9, d10, s10;
        idle         = '0;
        l2rsp_packet = '0;
        icache_req   = '0;
        dcache_req   = '0;
        stbuf_req    = '0;
        l2req_ready  = 1'b0;
        reset        = 1'b1;
        #2;
        checkOutput("reset packet t0", 128'(l2req_packet), 128'(0));
        checkOutput("reset readies", 128'({stbuf_ready, dcache_ready, icache_ready}), 128'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] single request");
        d0 = mk(2'd1, 40'h12345, 1'b0, 64'hD0);
        exp_q.push_back(d0);
        applyStimulus(idle, d0, idle, 1'b1, 3'b010, "single c0 ready");
        checkOutput("single c1 valid", 128'(l2req_packet.valid), 128'(1));
        checkOutput("single c1 unit", 128'(l2req_packet.unit), 128'(1));
        checkOutput("single c1 address", 128'(l2req_packet.address), 128'(40'h12345));
        applyStimulus(idle, idle, idle, 1'b1, 3'b000, "single c1 ready");
        checkOutput("single c2 valid", 128'(l2req_packet.valid), 128'(0));

        $display("[TB] round robin");
        doReset();
        a0 = mk(2'd0, 40'hA000, 1'b0, 64'hA0);
        a1 = mk(2'd0, 40'hA040, 1'b0, 64'hA1);
        d0 = mk(2'd1, 40'hD000, 1'b0, 64'hD0);
        d1 = mk(2'd1, 40'hD040, 1'b0, 64'hD1);
        s0 = mk(2'd2, 40'h5000, 1'b1, 64'h50);
        s1 = mk(2'd2, 40'h5040, 1'b1, 64'h51);
        exp_q.push_back(a0);
        applyStimulus(a0, d0, s0, 1'b1, 3'b001, "rr grant icache");
        exp_q.push_back(d0);
        applyStimulus(a1, d0, s0, 1'b1, 3'b010, "rr grant dcache");
        exp_q.push_back(s0);
        applyStimulus(a1, d1, s0, 1'b1, 3'b100, "rr grant stbuf");
        exp_q.push_back(a1);
        applyStimulus(a1, d1, s1, 1'b1, 3'b001, "rr grant icache again");
        exp_q.push_back(d1);
        applyStimulus(idle, d1, s1, 1'b1, 3'b010, "rr grant dcache again");
        exp_q.push_back(s1);
        applyStimulus(idle, idle, s1, 1'b1, 3'b100, "rr grant stbuf again");
        applyStimulus(idle, idle, idle, 1'b1, 3'b000, "rr drain");

        $display("[TB] backpressure");
        doReset();
        a0 = mk(2'd0, 40'hB000, 1'b0, 64'hB0);
        s0 = mk(2'd2, 40'hC000, 1'b1, 64'hC0);
        s1 = mk(2'd2, 40'hC040, 1'b1, 64'hC1);
        exp_q.push_back(s0);
        applyStimulus(idle, idle, s0, 1'b1, 3'b100, "bp fill");
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp stable packet", 128'(l2req_packet), 128'(s0));
            applyStimulus(a0, idle, s1, 1'b0, 3'b000, "bp stall ready");
        end
        checkOutput("bp stable packet end", 128'(l2req_packet), 128'(s0));
        exp_q.push_back(a0);
        applyStimulus(a0, idle, s1, 1'b1, 3'b001, "bp release icache");
        exp_q.push_back(s1);
        applyStimulus(idle, idle, s1, 1'b1, 3'b100, "bp then stbuf");
        applyStimulus(idle, idle, idle, 1'b1, 3'b000, "bp drain");

        $display("[TB] response decode");
        checkRsp(1'b1, CID, 2'd2, 3'b100, "rsp own core stbuf");
        checkRsp(1'b1, CID + 2'd1, 2'd1, 3'b000, "rsp other core");
        checkRsp(1'b0, CID, 2'd0, 3'b000, "rsp invalid");
        checkRsp(1'b1, CID, 2'd3, 3'b000, "rsp unit 3");
        checkRsp(1'b1, CID, 2'd0, 3'b001, "rsp own core icache");
        l2rsp_packet = '0;

        $display("[TB] reset mid-operation");
        d9  = mk(2'd1, 40'h99999, 1'b0, 64'h99);
        ix  = mk(2'd0, 40'hE000, 1'b0, 64'hE0);
        d10 = mk(2'd1, 40'hE100, 1'b0, 64'hE1);
        s10 = mk(2'd2, 40'hE200, 1'b1, 64'hE2);
        applyStimulus(idle, d9, idle, 1'b1, 3'b010, "mid capture d9");
        icache_req  = ix;
        dcache_req  = idle;
        l2req_ready = 1'b0;
        #1;
        checkOutput("mid held valid", 128'(l2req_packet.valid), 128'(1));
        checkOutput("mid stall ready", 128'({stbuf_ready, dcache_ready, icache_ready}), 128'(0));
        reset = 1'b1;
        #1;
        checkOutput("mid reset clears", 128'(l2req_packet.valid), 128'(0));
        checkOutput("mid reset readies", 128'({stbuf_ready, dcache_ready, icache_ready}),
                    128'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.push_back(ix);
        applyStimulus(ix, d10, s10, 1'b1, 3'b001, "mid first grant source0");
        exp_q.push_back(d10);
        applyStimulus(idle, d10, s10, 1'b1, 3'b010, "mid second grant");
        exp_q.push_back(s10);
        applyStimulus(idle, idle, s10, 1'b1, 3'b100, "mid third grant");
        applyStimulus(idle, idle, idle, 1'b1, 3'b000, "mid drain 1");
        applyStimulus(idle, idle, idle, 1'b1, 3'b000, "mid drain 2");

        checkOutput("scoreboard empty", 128'(exp_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
